// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and the unified memory.
// The slave modport is the arbiter's view; the master modport is the core/memory side.
interface mem_port_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  logic                 i_req;
  logic [WORD_SIZE-1:0] i_addr;
  logic [WORD_SIZE-1:0] i_rdata;
  logic                 i_done;
  logic                 i_stall;
  logic                 d_req;
  logic                 d_we;
  logic [WORD_SIZE-1:0] d_addr;
  logic [WORD_SIZE-1:0] d_wdata;
  logic [WORD_SIZE-1:0] d_rdata;
  logic                 d_done;
  logic                 d_stall;
  logic                 mem_read;
  logic                 mem_write;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 owner_d;
  logic                 busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
           mem_read, mem_write, mem_addr, mem_wdata, owner_d, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
           mem_read, mem_write, mem_addr, mem_wdata, owner_d, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one multi-cycle single-port memory,
// favouring data but forcing a fetch grant after STARVE_LIMIT consecutive data wins.
module mem_port_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  mem_port_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [7:0] LAT_M1     = 8'(LATENCY - 1);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  state_t               state_q, state_d;
  logic [7:0]           wait_cnt_q, wait_cnt_d;
  logic [7:0]           starve_cnt_q, starve_cnt_d;
  logic                 we_q, we_d;
  logic                 owner_d_q, owner_d_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
  logic                 i_done_q, i_done_d;
  logic                 d_done_q, d_done_d;
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;
  logic                 busy_q, busy_d;
  logic                 fetch_wins_s;

  // Next-state and next-output computation for the arbitration FSM.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    starve_cnt_d = starve_cnt_q;
    we_d         = we_q;
    owner_d_d    = owner_d_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    fetch_wins_s = bus.i_req && (!bus.d_req || (starve_cnt_q == STARVE_MAX));

    case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          state_d    = ACCESS;
          wait_cnt_d = LAT_M1;
          if (fetch_wins_s) begin
            owner_d_d    = 1'b0;
            addr_d       = bus.i_addr;
            we_d         = 1'b0;
            wdata_d      = '0;
            mem_read_d   = 1'b1;
            mem_write_d  = 1'b0;
            starve_cnt_d = 8'd0;
          end else begin
            owner_d_d   = 1'b1;
            addr_d      = bus.d_addr;
            we_d        = bus.d_we;
            wdata_d     = bus.d_wdata;
            mem_read_d  = ~bus.d_we;
            mem_write_d = bus.d_we;
            // A data win only counts against fetch if fetch was actually waiting.
            if (bus.i_req && (starve_cnt_q < STARVE_MAX)) begin
              starve_cnt_d = starve_cnt_q + 8'd1;
            end else if (bus.i_req) begin
              starve_cnt_d = starve_cnt_q;
            end else begin
              starve_cnt_d = 8'd0;
            end
          end
        end else begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      ACCESS: begin
        if (wait_cnt_q == 8'd0) begin
          state_d     = RESP;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          i_done_d    = ~owner_d_q;
          d_done_d    = owner_d_q;
          if (!we_q && owner_d_q) begin
            d_rdata_d = bus.mem_rdata;
          end else if (!we_q) begin
            i_rdata_d = bus.mem_rdata;
          end else begin
            d_rdata_d = d_rdata_q;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - 8'd1;
        end
      end
      RESP: begin
        state_d   = IDLE;
        owner_d_d = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        owner_d_d   = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, latches and registered outputs; reset aborts any in-flight access.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= 8'd0;
      starve_cnt_q <= 8'd0;
      we_q         <= 1'b0;
      owner_d_q    <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      we_q         <= we_d;
      owner_d_q    <= owner_d_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_done    = i_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.i_stall   = bus.i_req & ~i_done_q;
  assign bus.d_stall   = bus.d_req & ~d_done_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.owner_d   = owner_d_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified, multi-cycle, single-port memory between the pipeline's instruction-fetch side and data-access side.
- Sits between the pipelined CPU core's i_/d_ memory interfaces and the memory model.
- Serialises accesses, drives per-side stall signals for the hazard logic, and prevents fetch starvation with a bounded-priority counter.

Parameters:
WORD_SIZE, 16, address and data width
LATENCY, 2, memory access cycles per transaction (1..255)
STARVE_LIMIT, 4, consecutive data grants with fetch pending before fetch is forced to win (1..255)

Ports:
Clk  in  1  clock; all state changes on rising edge
Reset  in  1  asynchronous, active-high reset
i_req  in  1  fetch request; held until i_done
i_addr  in  WORD_SIZE  fetch address
i_rdata  out  WORD_SIZE  fetched word; valid while i_done=1
i_done  out  1  one-cycle completion pulse to fetch side
i_stall  out  1  i_req & ~i_done
d_req  in  1  data request; held until d_done
d_we  in  1  1=write, 0=read
d_addr  in  WORD_SIZE  data address
d_wdata  in  WORD_SIZE  store data
d_rdata  out  WORD_SIZE  load data; valid while d_done=1
d_done  out  1  one-cycle completion pulse to data side
d_stall  out  1  d_req & ~d_done
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  WORD_SIZE  memory address
mem_wdata  out  WORD_SIZE  memory write data
mem_rdata  in  WORD_SIZE  memory read data; valid in last ACCESS cycle
owner_d  out  1  1 while the current transaction belongs to the data side
busy  out  1  state != IDLE

Behaviour:
- Reset value of every output and register is 0; state is IDLE, and wait_cnt and starve_cnt are 0.
- Reset takes effect asynchronously: any in-flight access is aborted with no done pulse, and requesters must reissue.
- States:
  - IDLE: arbitrate.
  - ACCESS: strobes active for LATENCY cycles.
  - RESP: one cycle, done pulse.
- IDLE arbitration, on a rising edge with any request high:
  - Winner is data, unless i_req=1 and starve_cnt==STARVE_LIMIT; then fetch wins.
  - Latch owner, address, we, and wdata (zero for fetch).
  - Load wait_cnt=LATENCY-1 and go to ACCESS.
- starve_cnt update, at each grant:
  - Data granted while i_req=1: starve_cnt+1, saturating at STARVE_LIMIT.
  - Fetch granted, or data granted with i_req=0: starve_cnt=0.
- ACCESS:
  - mem_read=~we and mem_write=we on every cycle; mem_addr and mem_wdata come from latches and stay stable throughout.
  - wait_cnt decrements each cycle.
  - At wait_cnt==0, capture mem_rdata into the owner's rdata register (writes capture nothing) and go to RESP.
- RESP:
  - Owner's done=1 for exactly one cycle; strobes are 0.
  - Go to IDLE next edge. Requests are not sampled in RESP.
- Latency: from the request-sampled edge, done is high in cycle LATENCY+1. Minimum request spacing per transaction is LATENCY+2 cycles.
- Simultaneous requests: the loser remains stalled and is served in the next IDLE cycle.
- Requester holding req past done: treated as a new request at the next IDLE sample.
- Idle bus: no requests leaves the arbiter in IDLE with strobes 0.
- Stability: i_rdata and d_rdata hold their last captured value between transactions; the non-owner's rdata is unchanged.
- Write data: memory writes never drive rdata.
- Counter width: wait_cnt and starve_cnt are 8-bit, with no wrap-around (starve_cnt saturates).

Test Plan:
- Fetch only, LATENCY=2: i_req=1 with i_addr=0x0010 and mem_rdata=0xBEEF → mem_read high for 2 cycles, then i_done pulses with i_rdata=0xBEEF in cycle 3; i_stall high in cycles 0-2.
- Data write: d_req=1, d_we=1, d_addr=0x0100, d_wdata=0x1234 → mem_write=1 and mem_addr=0x0100 for 2 cycles, then d_done pulses; mem_read stays 0 and d_rdata is unchanged.
- Simultaneous i_req and d_req, starve_cnt=0 → data served first (owner_d=1), fetch next; fetch's i_done occurs exactly LATENCY+2 cycles after d_done.
- Starvation, STARVE_LIMIT=4: i_req and d_req held continuously → four data grants, then a fetch grant, then the pattern repeats.
- Reset asserted mid-ACCESS → strobes, done, busy, and owner_d drop asynchronously with no done pulse; after release and a reissued request, the transaction completes normally.
- LATENCY=1, back-to-back fetches (i_req held) → i_done every 3 cycles with the correct, distinct rdata values.
